alu_arbiter: RTL and testbench

Round-robin arbiter and result buffer that shares one instance of the existing combinational `ALU` between `NUM_REQ` requesters (execute, branch-compare, address-gen). It applies valid/ready handshakes on both sides and registers one result per accepted operation. It returns that result to the requester that issued it. Throughput is one operation per cycle when the receiver never stalls.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/ALU.sv | 33 +++
 rtl/alu_rr_pick.sv | 34 +++
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, widths, status bit positions and arbiter state type.
package alu_pkg;

  localparam int ALU_W    = 32;
  localparam int STATUS_W = 3;
  localparam int OP_W     = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_SLL = 4'd5;
  localparam logic [OP_W-1:0] OP_SRL = 4'd6;
  localparam logic [OP_W-1:0] OP_SRA = 4'd7;
  localparam logic [OP_W-1:0] OP_MUL = 4'd8;

  localparam int ST_EQ  = 0;
  localparam int ST_LTS = 1;
  localparam int ST_LTU = 2;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ALU.sv
// Combinational 32-bit ALU; shifts take the amount from a_i[4:0] and shift b_i.
module ALU
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0]    a_i,
  input  logic [ALU_W-1:0]    b_i,
  input  logic [OP_W-1:0]     op_i,
  output logic [ALU_W-1:0]    out_o,
  output logic [STATUS_W-1:0] status_o
);

  always_comb begin
    out_o = a_i + b_i;
    case (op_i)
      OP_ADD:  out_o = a_i + b_i;
      OP_SUB:  out_o = a_i - b_i;
      OP_AND:  out_o = a_i & b_i;
      OP_OR:   out_o = a_i | b_i;
      OP_XOR:  out_o = a_i ^ b_i;
      OP_SLL:  out_o = b_i << a_i[4:0];
      OP_SRL:  out_o = b_i >> a_i[4:0];
      OP_SRA:  out_o = $unsigned($signed(b_i) >>> a_i[4:0]);
      OP_MUL:  out_o = a_i * b_i;
      default: out_o = a_i + b_i;
    endcase

    status_o         = '0;
    status_o[ST_EQ]  = (a_i == b_i);
    status_o[ST_LTS] = ($signed(a_i) < $signed(b_i));
    status_o[ST_LTU] = (a_i < b_i);
  end

endmodule

// File: rtl/alu_rr_pick.sv
// Rotate-priority picker: first eligible valid requester at or after rr_ptr_i, wrapping.
module alu_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_valid_i,
  input  logic [IW-1:0] rr_ptr_i,
  input  logic [N-1:0]  elig_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin : pick
    int          j;
    logic [IW-1:0] j_idx;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    j_idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_ptr_i) + k;
      if (j >= N) j = j - N;
      j_idx = IW'(j);
      if (!any_o && req_valid_i[j_idx] && elig_i[j_idx]) begin
        any_o          = 1'b1;
        grant_o[j_idx] = 1'b1;
        idx_o          = j_idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between NUM_REQ requesters with a one-entry result register.
// Optional grant locking under `ALU_ARB_LOCK_EN (adds req_lock port).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ALU_W-1:0]  req_a,
  input  logic [NUM_REQ*ALU_W-1:0]  req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [ALU_W-1:0]          resp_out,
  output logic [STATUS_W-1:0]       resp_status,
  output logic                      busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t           state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ALU_W-1:0]     out_q, out_d;
  logic [STATUS_W-1:0]  status_q, status_d;

  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   elig;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        rr_next;
  logic [IW-1:0]        alu_sel;
  logic                 any_vld;
  logic                 owner_rdy;
  logic                 can_accept;
  logic                 accept;

  logic [ALU_W-1:0]     a_arr  [NUM_REQ];
  logic [ALU_W-1:0]     b_arr  [NUM_REQ];
  logic [OP_W-1:0]      op_arr [NUM_REQ];
  logic [ALU_W-1:0]     alu_out;
  logic [STATUS_W-1:0]  alu_status;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign a_arr[g]  = req_a[g*ALU_W +: ALU_W];
    assign b_arr[g]  = req_b[g*ALU_W +: ALU_W];
    assign op_arr[g] = req_op[g*OP_W +: OP_W];
  end

`ifdef ALU_ARB_LOCK_EN
  logic          lock_v_q, lock_v_d;
  logic [IW-1:0] lock_id_q, lock_id_d;
  assign elig = lock_v_q ? (NUM_REQ'(1) << lock_id_q) : '1;
`else
  assign elig = '1;
`endif

  alu_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .elig_i      (elig),
    .grant_o     (grant),
    .idx_o       (win_idx),
    .any_o       (any_vld)
  );

  // A drain and a fresh accept may share the same cycle.
  assign owner_rdy  = resp_ready[owner_q];
  assign can_accept = (state_q == ARB_EMPTY) || owner_rdy;
  assign accept     = any_vld && can_accept && !rst;
  assign req_ready  = accept ? grant : '0;
  assign rr_next    = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  // Idle cycles steer requester 0 into the ALU; the result is simply not captured.
  assign alu_sel = accept ? win_idx : '0;

  ALU u_alu (
    .a_i      (a_arr[alu_sel]),
    .b_i      (b_arr[alu_sel]),
    .op_i     (op_arr[alu_sel]),
    .out_o    (alu_out),
    .status_o (alu_status)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    out_d    = out_q;
    status_d = status_q;
`ifdef ALU_ARB_LOCK_EN
    lock_v_d  = lock_v_q;
    lock_id_d = lock_id_q;
`endif
    if (accept) begin
      state_d  = ARB_FULL;
      owner_d  = win_idx;
      out_d    = alu_out;
      status_d = alu_status;
`ifdef ALU_ARB_LOCK_EN
      if (req_lock[win_idx]) begin
        rr_ptr_d  = win_idx;
        lock_v_d  = 1'b1;
        lock_id_d = win_idx;
      end else begin
        rr_ptr_d = rr_next;
        lock_v_d = 1'b0;
      end
`else
      rr_ptr_d = rr_next;
`endif
    end else if (state_q == ARB_FULL && owner_rdy) begin
      state_d = ARB_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_EMPTY;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      out_q     <= '0;
      status_q  <= '0;
`ifdef ALU_ARB_LOCK_EN
      lock_v_q  <= 1'b0;
      lock_id_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      out_q     <= out_d;
      status_q  <= status_d;
`ifdef ALU_ARB_LOCK_EN
      lock_v_q  <= lock_v_d;
      lock_id_q <= lock_id_d;
`endif
    end
  end

  assign resp_valid  = (state_q == ARB_FULL) ? (NUM_REQ'(1) << owner_q) : '0;
  assign busy        = (state_q == ARB_FULL);
  assign resp_out    = out_q;
  assign resp_status = status_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level reference model checked every cycle.
module tb_alu_arbiter;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N*4-1:0]  req_op;
`ifdef ALU_ARB_LOCK_EN
  logic [N-1:0]  req_lock;
`endif
  logic [N-1:0]  resp_valid;
  logic [N-1:0]  resp_ready;
  logic [31:0]   resp_out;
  logic [2:0]    resp_status;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
`ifdef ALU_ARB_LOCK_EN
    .req_lock    (req_lock),
`endif
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_out    (resp_out),
    .resp_status (resp_status),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_hold    = 1'b0;
  int          m_owner   = 0;
  logic [31:0] m_out     = '0;
  logic [2:0]  m_st      = '0;
  int          m_rr      = 0;
  bit          m_lock_v  = 1'b0;
  int          m_lock_id = 0;

  function automatic logic [31:0] ref_out(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return b << a[4:0];
      4'd6:    return b >> a[4:0];
      4'd7:    return $unsigned($signed(b) >>> a[4:0]);
      4'd8:    return a * b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [2:0] ref_st(input logic [31:0] a, input logic [31:0] b);
    return {a < b, $signed(a) < $signed(b), a == b};
  endfunction

  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (req_valid[j] && (!m_lock_v || j == m_lock_id)) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int w;
    if (rst) return '0;
    w = model_winner();
    if (w >= 0 && (!m_hold || resp_ready[m_owner])) return N'(1) << w;
    return '0;
  endfunction

  always @(posedge clk or posedge rst) begin : model_upd
    int w;
    if (rst) begin
      m_hold <= 1'b0; m_owner <= 0; m_out <= '0; m_st <= '0;
      m_rr <= 0; m_lock_v <= 1'b0; m_lock_id <= 0;
    end else begin
      w = model_winner();
      if (w >= 0 && (!m_hold || resp_ready[m_owner])) begin
        m_hold  <= 1'b1;
        m_owner <= w;
        m_out   <= ref_out(req_op[w*4 +: 4], req_a[w*32 +: 32], req_b[w*32 +: 32]);
        m_st    <= ref_st(req_a[w*32 +: 32], req_b[w*32 +: 32]);
`ifdef ALU_ARB_LOCK_EN
        if (req_lock[w]) begin
          m_rr <= w; m_lock_v <= 1'b1; m_lock_id <= w;
        end else begin
          m_rr <= (w + 1) % N; m_lock_v <= 1'b0;
        end
`else
        m_rr <= (w + 1) % N;
`endif
      end else if (m_hold && resp_ready[m_owner]) begin
        m_hold <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_req_ready", 32'(req_ready), 32'(exp_ready()));
    check("cmp_resp_valid", 32'(resp_valid), m_hold ? 32'(N'(1) << m_owner) : 32'd0);
    check("cmp_busy", 32'(busy), 32'(m_hold));
    check("cmp_resp_out", resp_out, m_out);
    check("cmp_resp_status", 32'(resp_status), 32'(m_st));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]       = v;
    req_op[i*4 +: 4]   = op;
    req_a[i*32 +: 32]  = a;
    req_b[i*32 +: 32]  = b;
  endtask

  logic [3:0]  t_op  [8] = '{4'h2, 4'h4, 4'h6, 4'h7, 4'h8, 4'h5, 4'h3, 4'hF};
  logic [31:0] t_a   [8] = '{32'hFF00FF00, 32'hAAAA5555, 32'd4, 32'd4,
                             32'h00010001, 32'h21, 32'hF0, 32'd1};
  logic [31:0] t_b   [8] = '{32'h0F0F0F0F, 32'hFFFF0000, 32'h80000000, 32'h80000000,
                             32'h00010000, 32'd3, 32'h0F, 32'd2};
  logic [31:0] t_exp [8] = '{32'h0F000F00, 32'h55555555, 32'h08000000, 32'hF8000000,
                             32'h00010000, 32'd6, 32'hFF, 32'd3};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0; resp_ready = 2'b11;
`ifdef ALU_ARB_LOCK_EN
    req_lock = '0;
`endif
    #1 req_valid = 2'b11;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_out", resp_out, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0; req_valid = '0;
    cyc();

    // single operation
    set_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
    @(negedge clk);
    check("single_rdy", 32'(req_ready), 32'b01);
    cyc();
    req_valid[0] = 1'b0;
    check("single_valid", 32'(resp_valid), 32'b01);
    check("single_out", resp_out, 32'd12);
    check("single_status", 32'(resp_status), 32'b110);
    check("single_busy", 32'(busy), 32'd1);
    check("model_single", m_out, 32'd12);
    cyc();
    check("single_drain", 32'(resp_valid), 32'd0);

    // one req1 op, leaves rr pointing at 0
    set_req(1, 1'b1, 4'd5, 32'd4, 32'd1);
    cyc();
    req_valid[1] = 1'b0;
    check("sll_out", resp_out, 32'd16);
    check("sll_valid", 32'(resp_valid), 32'b10);

    // contention: grants alternate 0,1,0,1
    set_req(0, 1'b1, 4'd1, 32'd3, 32'd5);
    set_req(1, 1'b1, 4'd5, 32'd4, 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("cont_rdy", 32'(req_ready), (c % 2 == 0) ? 32'b01 : 32'b10);
      cyc();
      check("cont_valid", 32'(resp_valid), (c % 2 == 0) ? 32'b01 : 32'b10);
      check("cont_out", resp_out, (c % 2 == 0) ? 32'hFFFFFFFE : 32'd16);
      check("cont_status", 32'(resp_status), (c % 2 == 0) ? 32'b110 : 32'b000);
    end
    check("model_rr", 32'(m_rr), 32'd0);
    req_valid = '0;
    cyc();
    check("cont_drain", 32'(busy), 32'd0);

    // backpressure
    resp_ready = 2'b00;
    set_req(0, 1'b1, 4'd0, 32'd10, 32'd20);
    cyc();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 4'd3, 32'hF0, 32'h0F);
    check("bp_first", resp_out, 32'd30);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_rdy", 32'(req_ready), 32'd0);
      check("bp_stable", resp_out, 32'd30);
      check("bp_valid", 32'(resp_valid), 32'b01);
      cyc();
    end
    resp_ready = 2'b01;
    @(negedge clk);
    check("bp_release_rdy", 32'(req_ready), 32'b10);
    cyc();
    check("bp_new_owner", 32'(resp_valid), 32'b10);
    check("bp_new_out", resp_out, 32'hFF);
    req_valid[1] = 1'b0;
    cyc();
    check("nonowner_ignored", 32'(resp_valid), 32'b10);
    resp_ready = 2'b11;
    cyc();
    check("bp_drain", 32'(busy), 32'd0);

    // opcode table, back-to-back on requester 0
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b1, t_op[i], t_a[i], t_b[i]);
      cyc();
      check("op_table", resp_out, t_exp[i]);
    end
    req_valid = '0;
    resp_ready = 2'b00;
    cyc();
    check("held_before_rst", 32'(resp_valid), 32'b01);

    // asynchronous reset while FULL
    req_valid = 2'b11;
    #2 rst = 1'b1;
    #1;
    check("rstmid_valid", 32'(resp_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_out", resp_out, 32'd0);
    check("rstmid_status", 32'(resp_status), 32'd0);
    check("rstmid_rdy", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    resp_ready = 2'b11;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'b01);
    cyc();
    check("post_rst_out", resp_out, 32'd3);
    req_valid = '0;
    cyc();

`ifdef ALU_ARB_LOCK_EN
    req_valid = 2'b10; req_lock = 2'b10;
    @(negedge clk);
    check("lock_first", 32'(req_ready), 32'b10);
    cyc();
    req_valid = 2'b11;
    @(negedge clk);
    check("lock_hold1", 32'(req_ready), 32'b10);
    cyc();
    req_lock = 2'b00;
    @(negedge clk);
    check("lock_hold2", 32'(req_ready), 32'b10);
    cyc();
    @(negedge clk);
    check("after_unlock", 32'(req_ready), 32'b01);
    cyc();
    req_valid = '0;
    cyc();
`endif

    cyc();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
